// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters, one transaction at a time.
// Define ARB_LOCK_EN to let the owner keep the port across transactions while its req_lock is high.
module memory_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [NREQ-1:0]    req_ren,
   input  logic [NREQ-1:0]    req_wen,
   input  logic [NREQ-1:0]    req_lock,
   input  logic [NREQ*32-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_store,
   output logic [NREQ-1:0]    req_done,
   output logic [NREQ-1:0]    req_err,
   output logic [31:0]        req_load,
   output logic               gnt_valid,
   output logic [IDW-1:0]     gnt_id,
   output logic               ramREN,
   output logic               ramWEN,
   output logic [31:0]        ramaddr,
   output logic [31:0]        ramstore,
   input  logic [31:0]        ramload,
   input  logic [1:0]         ramstate
);

   // state  | meaning
   // IDLE   | no transaction; pick next pending requester from ptr
   // ISSUE  | drive latched request to RAM until ACCESS or ERROR
   // DONE   | one-cycle req_done to owner, advance ptr
   // ERR    | one-cycle req_err to owner, advance ptr
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE, S_ERR} state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      store_q, store_d;
   logic             wen_q, wen_d;
   logic [31:0]      load_q, load_d;

   logic [NREQ-1:0]  pend;
   logic             found;
   logic [IDW-1:0]   pick;
   logic [IDW-1:0]   next_ptr;

   assign pend = req_ren | req_wen;

   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && pend[(int'(ptr_q) + i) % NREQ]) begin
            found = 1'b1;
            pick  = IDW'((int'(ptr_q) + i) % NREQ);
         end
      end
   end

   assign next_ptr = (int'(gnt_id_q) == NREQ - 1) ? '0 : gnt_id_q + IDW'(1);

`ifndef ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^req_lock;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_id_d = gnt_id_q;
      addr_d   = addr_q;
      store_d  = store_q;
      wen_d    = wen_q;
      load_d   = load_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      req_done = '0;
      req_err  = '0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d  = S_ISSUE;
               gnt_id_d = pick;
               addr_d   = req_addr[32*int'(pick) +: 32];
               store_d  = req_store[32*int'(pick) +: 32];
               wen_d    = req_wen[pick];
            end
         end
         S_ISSUE: begin
            // RAM only ever sees the latched copy, so requester churn is invisible here
            ramREN   = ~wen_q;
            ramWEN   = wen_q;
            ramaddr  = addr_q;
            ramstore = store_q;
            if (ramstate == RAM_ACCESS) begin
               state_d = S_DONE;
               load_d  = ramload;
            end else if (ramstate == RAM_ERROR) begin
               state_d = S_ERR;
            end
         end
         S_DONE: begin
            req_done[gnt_id_q] = 1'b1;
            state_d            = S_IDLE;
            ptr_d              = next_ptr;
`ifdef ARB_LOCK_EN
            // pointing ptr at the owner makes it first in the next search
            if (req_lock[gnt_id_q]) ptr_d = gnt_id_q;
`endif
         end
         S_ERR: begin
            req_err[gnt_id_q] = 1'b1;
            state_d           = S_IDLE;
            ptr_d             = next_ptr;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         gnt_id_q <= '0;
         addr_q   <= '0;
         store_q  <= '0;
         wen_q    <= 1'b0;
         load_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_id_q <= gnt_id_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         wen_q    <= wen_d;
         load_q   <= load_d;
      end
   end

   assign gnt_valid = (state_q != S_IDLE);
   assign gnt_id    = gnt_id_q;
   assign req_load  = load_q;

endmodule
